// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream into the instruction encoder/loader.
// Valid/ready: a bundle transfers on a rising edge where s_valid && s_ready; fields must be stable while s_valid is high.
interface instr_encoder_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    modport master (
        output s_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  s_ready
    );

    modport slave (
        input  s_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output s_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Assembles RV32I words from field bundles and writes them sequentially into
// instruction memory via a one-cycle-latency write port.
module instr_encoder_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    instr_encoder_loader_if.slave  src,
    output logic                   im_we,
    output logic [ADDR_W-1:0]      im_addr,
    output logic [31:0]            im_wdata,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   err,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FULL = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t          state, state_nxt;
    logic [31:0]     word;
    logic            legal;
    logic            accept;
    logic [ADDR_W:0] count_inc;

    // Encoder: fmt codes follow the decoder's imm_src (I=0 S=1 B=2 U=3 J=4 R=5).
    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (src.fmt)
            3'd0: begin
                word  = {src.imm[11:0], src.rs1, src.funct3, src.rd, src.opcode};
                legal = (src.imm[31:11] == {21{src.imm[11]}});
            end
            3'd1: begin
                word  = {src.imm[11:5], src.rs2, src.rs1, src.funct3, src.imm[4:0], src.opcode};
                legal = (src.imm[31:11] == {21{src.imm[11]}});
            end
            3'd2: begin
                word  = {src.imm[12], src.imm[10:5], src.rs2, src.rs1, src.funct3,
                         src.imm[4:1], src.imm[11], src.opcode};
                legal = (src.imm[31:12] == {20{src.imm[12]}}) && !src.imm[0];
            end
            3'd3: begin
                word  = {src.imm[31:12], src.rd, src.opcode};
                legal = (src.imm[11:0] == 12'h0);
            end
            3'd4: begin
                word  = {src.imm[20], src.imm[10:1], src.imm[11], src.imm[19:12], src.rd, src.opcode};
                legal = (src.imm[31:20] == {12{src.imm[20]}}) && !src.imm[0];
            end
            3'd5: begin
                word  = {src.funct7, src.rs2, src.rs1, src.funct3, src.rd, src.opcode};
                legal = 1'b1;
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

    assign accept    = src.s_valid && src.s_ready;
    assign count_inc = count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (!legal)                    state_nxt = S_ERR;
                        else if (count_inc == DEPTH_C) state_nxt = S_FULL;
                    end
                end
                S_FULL:  state_nxt = S_FULL;
                S_ERR:   state_nxt = S_ERR;
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    // s_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        src.s_ready = 1'b0;
        full        = 1'b0;
        err         = 1'b0;
        dbg_state   = state;
        case (state)
            S_LOAD:  src.s_ready = rst_n && !flush;
            S_FULL:  full = 1'b1;
            S_ERR:   err  = 1'b1;
            default: src.s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'h0;
            count    <= '0;
        end else if (flush) begin
            im_we   <= 1'b0;
            im_addr <= '0;
            count   <= '0;
        end else if (accept && legal) begin
            im_we    <= 1'b1;
            im_addr  <= count[ADDR_W-1:0];
            im_wdata <= word;
            count    <= count_inc;
        end else begin
            im_we <= 1'b0;
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's opcode/immediate decode path: accepts instruction fields over a valid/ready stream and assembles legal RV32I 32-bit words.
- Formats supported: R/I/S/B/U/J.
- Writes each assembled word sequentially into instruction memory through a one-cycle-latency write port.
- Used by the test/boot infrastructure to load programs into the single-cycle core's instruction memory without an external assembler.

Parameters:
- DEPTH, 256, instruction-memory capacity in words; must be a power of two ≥ 2.
- ADDR_W, 8, word-address width; equals log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear: count/address to 0, state to S_LOAD
- s_valid  in  1  field bundle valid
- s_ready  out  1  encoder can accept a bundle
- fmt  in  3  format select: I=0, S=1, B=2, U=3, J=4, R=5; 6/7 illegal (same encoding as the decoder's imm_src)
- opcode  in  7  opcode field, inserted verbatim
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R only)
- imm  in  32  full byte-offset/value immediate, not pre-shifted
- im_we  out  1  instruction-memory write enable
- im_addr  out  ADDR_W  word address of im_wdata
- im_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/flush
- full  out  1  count == DEPTH
- err  out  1  sticky encode error

Behaviour:
- Reset (rst_n low, asynchronous): im_we=0, im_addr=0, im_wdata=0, count=0, full=0, err=0, state=S_LOAD. s_ready=0 while rst_n is low.
- States and s_ready:
  - S_LOAD: s_ready=1.
  - S_FULL: s_ready=0, full=1.
  - S_ERR: s_ready=0, err=1.
- Accept occurs on a cycle with s_valid && s_ready. Bundle fields are sampled on that edge.
- Latency: on the edge after an accept, im_we=1 for exactly one cycle, with im_addr = count before increment and im_wdata = encoded word. count increments on that same edge.
- Throughput is one accept per cycle; back-to-back accepts produce consecutive im_we pulses at consecutive addresses.
- Encoding, MSB→LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Legality checks, evaluated on the accepted bundle:
  - I/S: imm equals sign-extension of imm[11:0].
  - B: imm equals sign-extension of imm[12:0], and imm[0]=0.
  - J: imm equals sign-extension of imm[20:0], and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
  - fmt 6/7: always illegal.
- Illegal bundle: no write; im_we stays 0; count unchanged; err=1; state→S_ERR.
- Transitions:
  - S_LOAD→S_FULL on the legal write that makes count==DEPTH.
  - S_LOAD→S_ERR on an illegal accept.
  - S_FULL and S_ERR are left only by flush or reset.
- Wrap-around: none. Address never wraps; at DEPTH, S_FULL blocks further accepts, so the last address written is DEPTH-1.
- flush:
  - Next edge: count=0, im_addr=0, err=0, full=0, state=S_LOAD, im_we=0.
  - flush has priority over a simultaneous accept; that bundle is dropped and not written.
  - s_ready is forced to 0 in any cycle where flush=1.
- Reset mid-write: an im_we pulse in flight is cleared immediately; count returns to 0.
- im_wdata and im_addr hold their last values when im_we=0.

Test Plan:
- Reset, then accept fmt=I, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 → next cycle im_we=1, im_addr=0, im_wdata=0x00500093, count=1.
- Back-to-back, one per cycle:
  - S: sw x2,8(x1): opcode=0100011, f3=010, rs1=1, rs2=2, imm=8
  - B: beq x0,x0,-4
  - J: jal x1,8
  - U: lui x5 with imm=0x12345000
  - R: add x3,x1,x2

  → im_wdata 0x0020A423, 0xFE000EE3, 0x008000EF, 0x123452B7, 0x002081B3 at addresses 0..4 on consecutive cycles.
- fmt=B with imm=6, then imm=3; separately fmt=7 → imm=6 written. imm=3 gives err=1, no im_we, count unchanged, s_ready=0 until flush. fmt=7 gives err=1 the same way.
- DEPTH=4 build, six valid bundles → four writes at addresses 0–3, full=1, s_ready=0, count=4; bundles 5–6 not accepted.
- flush asserted in the same cycle as s_valid → no write, count=0; next bundle is written at im_addr=0.
- rst_n pulsed low asynchronously between an accept and its write edge → im_we never asserts, all outputs zero, s_ready=1 after release.
